// File: rtl/pcihellocore_pio_pkg.sv
// Shared register map and edge-sensitivity encoding for the PIO input capture slave.
package pcihellocore_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_RSVD    = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_e;

  function automatic logic [31:0] edge_detect(input logic [31:0] cur,
                                              input logic [31:0] prev,
                                              input edge_type_e  sel);
    logic [31:0] rise;
    logic [31:0] fall;
    rise = cur & ~prev;
    fall = ~cur & prev;
    case (sel)
      EDGE_RISE: edge_detect = rise;
      EDGE_FALL: edge_detect = fall;
      default:   edge_detect = rise | fall;
    endcase
  endfunction

endpackage

// File: rtl/pcihellocore_pio_in_debounce.sv
// Single-bit debouncer: the filtered output follows the input only after the input
// has disagreed with it for DEBOUNCE_CYCLES consecutive clocks.
module pcihellocore_pio_in_debounce
  import pcihellocore_pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic filt
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             filt_q, filt_d;

  // Down-counter reloads whenever input agrees; terminal count commits the new level.
  always_comb begin
    cnt_d  = CNT_LOAD;
    filt_d = filt_q;
    if (raw != filt_q) begin
      if (cnt_q == '0) begin
        filt_d = raw;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= CNT_LOAD;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt = filt_q;

endmodule

// File: rtl/pcihellocore_pio_in_capture.sv
// Avalon-MM PIO input slave: synchronizes in_port, captures edges stickily, raises a masked irq.
// Optional per-bit debouncer enabled by defining PCIHELLOCORE_PIO_IN_DEBOUNCE_EN.
module pcihellocore_pio_in_capture
  import pcihellocore_pio_pkg::*;
#(
  parameter int          WIDTH           = 32,
  parameter int          EDGE_TYPE       = 0,
  parameter int          SYNC_STAGES     = 2,
  parameter logic [31:0] IRQ_MASK_RESET  = 32'h0,
  parameter int          DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int         ARM_MAX  = SYNC_STAGES + 1;
  localparam int         ARM_W    = $clog2(ARM_MAX + 1);
  localparam edge_type_e EDGE_SEL = edge_type_e'(EDGE_TYPE);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]                  s;
  logic [WIDTH-1:0]                  filt;
  logic [WIDTH-1:0]                  prev_q, prev_d;
  logic [WIDTH-1:0]                  edge_capture_q, edge_capture_d;
  logic [WIDTH-1:0]                  irq_mask_q, irq_mask_d;
  logic [31:0]                       readdata_q, readdata_d;
  logic [ARM_W-1:0]                  arm_q, arm_d;
  logic                              armed;
  logic                              wr_en;
  logic [31:0]                       edge_all;
  logic [WIDTH-1:0]                  edge_det;
  logic [WIDTH-1:0]                  clr_bits;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], in_port};
  assign s      = sync_q[SYNC_STAGES-1];

`ifdef PCIHELLOCORE_PIO_IN_DEBOUNCE_EN
  for (genvar b = 0; b < WIDTH; b++) begin : g_db
    pcihellocore_pio_in_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .reset_n(reset_n),
      .raw    (s[b]),
      .filt   (filt[b])
    );
  end
`else
  logic unused_debounce_cfg;
  assign unused_debounce_cfg = ^DEBOUNCE_CYCLES;
  assign filt = s;
`endif

  // Edge detection stays off until the synchronizer and prev sample hold real input data.
  assign armed = (arm_q == ARM_W'(ARM_MAX));
  assign arm_d = armed ? arm_q : arm_q + ARM_W'(1);

  assign prev_d   = filt;
  assign edge_all = edge_detect(32'(filt), 32'(prev_q), EDGE_SEL);
  assign edge_det = armed ? edge_all[WIDTH-1:0] : '0;
  assign wr_en    = chipselect & ~write_n;

  always_comb begin
    clr_bits   = '0;
    irq_mask_d = irq_mask_q;
    if (wr_en && (address == ADDR_EDGECAP)) begin
      clr_bits = writedata[WIDTH-1:0];
    end
    if (wr_en && (address == ADDR_IRQMASK)) begin
      irq_mask_d = writedata[WIDTH-1:0];
    end
    // A fresh edge outranks a same-cycle clear so no event is lost.
    edge_capture_d = (edge_capture_q & ~clr_bits) | edge_det;
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA:    readdata_d = 32'(filt);
      ADDR_IRQMASK: readdata_d = 32'(irq_mask_q);
      ADDR_RSVD:    readdata_d = '0;
      ADDR_EDGECAP: readdata_d = 32'(edge_capture_q);
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q         <= '0;
      prev_q         <= '0;
      edge_capture_q <= '0;
      irq_mask_q     <= IRQ_MASK_RESET[WIDTH-1:0];
      readdata_q     <= '0;
      arm_q          <= '0;
    end else begin
      sync_q         <= sync_d;
      prev_q         <= prev_d;
      edge_capture_q <= edge_capture_d;
      irq_mask_q     <= irq_mask_d;
      readdata_q     <= readdata_d;
      arm_q          <= arm_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edge_capture_q & irq_mask_q);

  // Reads have no side effects, so the strobe and unused write bits are intentionally ignored.
  logic unused_inputs;
  assign unused_inputs = ^{read_n, writedata};

endmodule

// File: tb/tb_pcihellocore_pio_in_capture.sv
// Self-checking bench: directed steps plus randomized traffic against an event-level model.
module tb_pcihellocore_pio_in_capture;

  localparam int W    = 32;
  localparam int N    = 2;
  localparam int ET   = 0;
  localparam int DB   = 16;
  localparam int MAXC = 8192;
`ifdef PCIHELLOCORE_PIO_IN_DEBOUNCE_EN
  localparam int DBL = DB;
`else
  localparam int DBL = 0;
`endif
  localparam int LAT    = N + 1 + DBL;
  localparam int SETTLE = 10 + DBL;
  localparam int PULSE  = 4 + DBL;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    address = 2'd0;
  logic          chipselect = 1'b0;
  logic          read_n = 1'b1;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = 32'h0;
  logic [31:0]   readdata;
  logic [W-1:0]  in_port = '0;
  logic          irq;

  pcihellocore_pio_in_capture #(
    .WIDTH(W), .EDGE_TYPE(ET), .SYNC_STAGES(N),
    .IRQ_MASK_RESET(32'h0), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .readdata(readdata), .in_port(in_port), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: in_at[k] is the input seen at the k-th edge after reset release.
  int           n;
  logic [W-1:0] in_at [MAXC];
  logic [W-1:0] m_filt, m_prev, m_mask, m_ecap;
  logic [31:0]  m_rd;
  int           m_run [W];

  function automatic logic [W-1:0] s_at(input int k);
    return (k < 1) ? '0 : in_at[k];
  endfunction

  task automatic model_reset();
    n = 0; m_filt = '0; m_prev = '0; m_mask = '0; m_ecap = '0; m_rd = '0;
    for (int b = 0; b < W; b++) m_run[b] = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [W-1:0] det;
`ifdef PCIHELLOCORE_PIO_IN_DEBOUNCE_EN
    logic [W-1:0] s_cur;
`endif
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      n++;
      if (n >= MAXC) begin
        $display("FAIL model_depth: cycle %0d exceeds %0d", n, MAXC);
        $fatal(1);
      end
      in_at[n] = in_port;
      det = '0;
      if (n >= N + 2) begin
        case (ET)
          0:       det = m_filt & ~m_prev;
          1:       det = ~m_filt & m_prev;
          default: det = m_filt ^ m_prev;
        endcase
      end
      case (address)
        2'd0:    m_rd = 32'(m_filt);
        2'd1:    m_rd = 32'(m_mask);
        2'd2:    m_rd = 32'h0;
        default: m_rd = 32'(m_ecap);
      endcase
      if (chipselect && !write_n) begin
        if (address == 2'd1) m_mask = writedata[W-1:0];
        if (address == 2'd3) m_ecap = m_ecap & ~writedata[W-1:0];
      end
      m_ecap = m_ecap | det;
      m_prev = m_filt;
`ifdef PCIHELLOCORE_PIO_IN_DEBOUNCE_EN
      s_cur = s_at(n - N);
      for (int b = 0; b < W; b++) begin
        if (s_cur[b] != m_filt[b]) begin
          m_run[b]++;
          if (m_run[b] == DB) begin
            m_filt[b] = s_cur[b];
            m_run[b] = 0;
          end
        end else begin
          m_run[b] = 0;
        end
      end
`else
      m_filt = s_at(n + 1 - N);
`endif
    end
    #1;
    chk("readdata", readdata, m_rd);
    chk("irq", 32'(irq), 32'(|(m_ecap & m_mask)));
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic random_phase(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      if ($urandom_range(3) == 0) in_port[$urandom_range(W-1)] ^= 1'b1;
      chipselect = 1'($urandom_range(1));
      write_n    = ($urandom_range(3) != 0);
      read_n     = 1'($urandom_range(1));
      address    = 2'($urandom_range(3));
      writedata  = $urandom & $urandom;
      tick();
    end
    chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
  endtask

  initial begin
    model_reset();
    in_port = '1;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (SETTLE) tick();
    address = 2'd3; tick();
    chk("ecap_after_reset", readdata, 32'h0);
    chk("irq_after_reset", 32'(irq), 32'h0);
    address = 2'd0; tick();
    chk("data_after_reset", readdata, 32'hFFFF_FFFF);

    // Rising edge on bit 0 with mask bit 0: exact capture latency, then W1C.
    bus_write(2'd1, 32'h1);
    in_port = '0;
    repeat (SETTLE) tick();
    bus_write(2'd3, 32'hFFFF_FFFF);
    in_port[0] = 1'b1;
    repeat (LAT - 1) tick();
    chk("irq_before_latency", 32'(irq), 32'h0);
    tick();
    chk("irq_at_latency", 32'(irq), 32'h1);
    address = 2'd3; tick();
    chk("ecap_bit0", readdata, 32'h1);
    bus_write(2'd3, 32'h1);
    chk("irq_after_w1c", 32'(irq), 32'h0);

    // Edge on bit 3 coinciding with its W1C: the set wins.
    in_port[3] = 1'b1;
    repeat (LAT + 1) tick();
    in_port[3] = 1'b0;
    repeat (LAT + 2) tick();
    in_port[3] = 1'b1;
    repeat (LAT - 1) tick();
    bus_write(2'd3, 32'h8);
    address = 2'd3; tick();
    chk("set_wins_bit3", readdata & 32'h8, 32'h8);
    bus_write(2'd3, 32'h8);
    address = 2'd3; tick();
    chk("w1c_bit3", readdata & 32'h8, 32'h0);

    // Short pulse on bit 5 with mask 0, then unmask.
    bus_write(2'd1, 32'h0);
    in_port = '0;
    repeat (LAT + 2) tick();
    bus_write(2'd3, 32'hFFFF_FFFF);
    in_port[5] = 1'b1;
    repeat (PULSE) tick();
    in_port[5] = 1'b0;
    repeat (LAT + 4) tick();
    address = 2'd3; tick();
    chk("ecap_bit5", readdata, 32'h20);
    chk("irq_masked", 32'(irq), 32'h0);
    bus_write(2'd1, 32'h20);
    chk("irq_unmasked", 32'(irq), 32'h1);

    // Writes to data and reserved words change nothing.
    bus_write(2'd0, 32'hDEAD_BEEF);
    bus_write(2'd2, 32'hDEAD_BEEF);
    address = 2'd2; tick();
    chk("rsvd_reads_zero", readdata, 32'h0);
    address = 2'd1; tick();
    chk("mask_kept", readdata, 32'h20);
    address = 2'd3; tick();
    chk("ecap_kept", readdata, 32'h20);

`ifdef PCIHELLOCORE_PIO_IN_DEBOUNCE_EN
    bus_write(2'd1, 32'h1);
    bus_write(2'd3, 32'hFFFF_FFFF);
    in_port[0] = 1'b1;
    repeat (5) tick();
    in_port[0] = 1'b0;
    repeat (40) tick();
    chk("glitch_rejected", 32'(irq), 32'h0);
    in_port[0] = 1'b1;
    repeat (LAT - 1) tick();
    chk("db_before_latency", 32'(irq), 32'h0);
    tick();
    chk("db_at_latency", 32'(irq), 32'h1);
    repeat (20) tick();
`endif

    random_phase(1500);

    // Asynchronous reset mid-cycle, released with all inputs high.
    in_port = '1;
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_reset_rd", readdata, 32'h0);
    chk("async_reset_irq", 32'(irq), 32'h0);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (SETTLE) tick();
    address = 2'd3; tick();
    chk("no_false_edge", readdata, 32'h0);

    random_phase(600);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
